keypad_event_encoder: RTL

Downstream consumer of the keypad scanner in the calculator datapath. It watches the scanner's level-style outputs (`key_pressed`, active column, latched row), converts each press into a 4-bit key code and emits one event per press, plus timed auto-repeat events while the key is held. Events are buffered in a small first-word-fall-through FIFO with a valid/ready handshake toward the calculator control FSM.

---
 rtl/keypad_event_encoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_event_encoder.sv
// Turns keypad scanner level outputs into one key-code event per press plus timed
// auto-repeat events, buffered in a first-word-fall-through FIFO with valid/ready.
module keypad_event_encoder #(
  parameter bit          REPEAT_EN    = 1'b1,
  parameter int unsigned REPEAT_DELAY = 6000000,
  parameter int unsigned REPEAT_RATE  = 1200000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [3:0] col_in,
  input  logic [3:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow,
  output logic       multi_key
);

  localparam int unsigned AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [23:0] DELAY_LAST = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] RATE_LAST  = 24'(REPEAT_RATE - 1);
  localparam logic [AW:0] FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2, LOCK = 2'd3} state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] idx4(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  state_e            state_q, state_d;
  logic              kp_q;
  logic [23:0]       timer_q, timer_d;
  logic [3:0]        code_q, code_d;
  logic              multi_key_q, multi_key_d;
  logic              overflow_q, overflow_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [3:0]        mem_q [FIFO_DEPTH];

  logic              rise_s, decode_ok_s, push_s, pop_s, full_s, wr_en_s;
  logic [3:0]        decode_s, push_code_s;

  assign rise_s      = key_pressed & ~kp_q;
  assign decode_ok_s = is_onehot4(row_in) & is_onehot4(col_in);
  // 4*row_idx + col_idx is just the two indices concatenated
  assign decode_s    = {idx4(row_in), idx4(col_in)};

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = (decode_ok_s && REPEAT_EN) ? DELAY : LOCK;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY: begin
        if (!key_pressed)              state_d = IDLE;
        else if (timer_q == DELAY_LAST) state_d = REPEAT;
        else                           state_d = DELAY;
      end
      REPEAT: begin
        if (!key_pressed) state_d = IDLE;
        else              state_d = REPEAT;
      end
      LOCK: begin
        if (!key_pressed) state_d = IDLE;
        else              state_d = LOCK;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: event pushes, repeat timer, captured code, reject pulse
  always_comb begin
    push_s      = 1'b0;
    push_code_s = code_q;
    timer_d     = timer_q;
    code_d      = code_q;
    multi_key_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = 24'd0;
        if (rise_s && decode_ok_s) begin
          push_s      = 1'b1;
          push_code_s = decode_s;
          code_d      = decode_s;
        end else if (rise_s) begin
          multi_key_d = 1'b1;
        end else begin
          multi_key_d = 1'b0;
        end
      end
      DELAY: begin
        // release wins over a coinciding repeat push
        if (!key_pressed) begin
          timer_d = 24'd0;
        end else if (timer_q == DELAY_LAST) begin
          push_s  = 1'b1;
          timer_d = 24'd0;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      REPEAT: begin
        if (!key_pressed) begin
          timer_d = 24'd0;
        end else if (timer_q == RATE_LAST) begin
          push_s  = 1'b1;
          timer_d = 24'd0;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      LOCK:    timer_d = 24'd0;
      default: timer_d = 24'd0;
    endcase
  end

  // FIFO pointers, occupancy, sticky overflow and registered head
  always_comb begin
    pop_s      = key_valid_q & key_ready;
    full_s     = (count_q == FULL_CNT);
    wr_en_s    = push_s & (~full_s | pop_s);
    overflow_d = overflow_q | (push_s & full_s & ~pop_s);
    rd_ptr_d   = pop_s   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    key_valid_d = (count_d != (AW + 1)'(0));
    // the new head may be the entry being written this cycle
    if (count_d == (AW + 1)'(0)) begin
      key_code_d = 4'd0;
    end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
      key_code_d = push_code_s;
    end else begin
      key_code_d = mem_q[rd_ptr_d];
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      kp_q        <= 1'b0;
      timer_q     <= 24'd0;
      code_q      <= 4'd0;
      multi_key_q <= 1'b0;
      overflow_q  <= 1'b0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'd0;
    end else begin
      state_q     <= state_d;
      kp_q        <= key_pressed;
      timer_q     <= timer_d;
      code_q      <= code_d;
      multi_key_q <= multi_key_d;
      overflow_q  <= overflow_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      if (wr_en_s) mem_q[wr_ptr_q] <= push_code_s;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overflow  = overflow_q;
  assign multi_key = multi_key_q;

endmodule
